// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: widths, opcodes, instruction field positions and
// the imm5 sign-extension helper.
package lc3_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 3;
  localparam int NREG      = 8;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam int OPC_HI  = 15;
  localparam int DR_HI   = 11;
  localparam int SR1_HI  = 8;
  localparam int IMM_BIT = 5;
  localparam int SR2_HI  = 2;

  function automatic logic [DATA_W-1:0] sext_imm5(input logic [4:0] f);
    return {{(DATA_W-5){f[4]}}, f};
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// 8-entry register file: two combinational read ports, one write port.
// Reads return the stored value only; forwarding is the caller's job.
module lc3_regfile
  import lc3_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] rd1_idx,
  output logic [W-1:0]         rd1_data,
  input  logic [REG_IDX_W-1:0] rd2_idx,
  output logic [W-1:0]         rd2_data,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [W-1:0]         wr_data
);

  logic [NREG-1:0][W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rd1_data = regs_q[rd1_idx];
  assign rd2_data = regs_q[rd2_idx];

endmodule

// File: rtl/lc3_operand_fetch.sv
// LC-3 decode/operand-fetch stage: captures an instruction, reads SR1/SR2 with
// writeback bypass, and holds the operand bundle in a one-entry valid/ready slot.
module lc3_operand_fetch
  import lc3_pkg::*;
#(
  parameter int DATA_W = lc3_pkg::DATA_W,
  parameter int NREG   = lc3_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ir_valid,
  input  logic [15:0]          ir,
  output logic                 ir_ready,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [3:0]           opcode,
  output logic [2:0]           dr,
  output logic [DATA_W-1:0]    sr1_val,
  output logic [DATA_W-1:0]    sr2_val,
  output logic [DATA_W-1:0]    imm5_sext,
  output logic                 sr2_sel,
  input  logic                 wb_en,
  input  logic [2:0]           wb_dr,
  input  logic [DATA_W-1:0]    wb_data
);

  logic              op_valid_q, op_valid_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [2:0]        dr_q, dr_d;
  logic [2:0]        sr1_idx_q, sr1_idx_d;
  logic [2:0]        sr2_idx_q, sr2_idx_d;
  logic [DATA_W-1:0] sr1_val_q, sr1_val_d;
  logic [DATA_W-1:0] sr2_val_q, sr2_val_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              sr2_sel_q, sr2_sel_d;

  logic [2:0]        ir_sr1, ir_sr2;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic              capture, held;

  assign ir_sr1 = ir[SR1_HI -: 3];
  assign ir_sr2 = ir[SR2_HI -: 3];

  lc3_regfile #(.W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd1_idx  (ir_sr1),
    .rd1_data (rf_rd1),
    .rd2_idx  (ir_sr2),
    .rd2_data (rf_rd2),
    .wr_en    (wb_en),
    .wr_idx   (wb_dr),
    .wr_data  (wb_data)
  );

  assign ir_ready = !op_valid_q || op_ready;
  assign capture  = ir_valid && ir_ready;
  assign held     = op_valid_q && !op_ready;

  always_comb begin
    op_valid_d = op_valid_q;
    opcode_d   = opcode_q;
    dr_d       = dr_q;
    sr1_idx_d  = sr1_idx_q;
    sr2_idx_d  = sr2_idx_q;
    sr1_val_d  = sr1_val_q;
    sr2_val_d  = sr2_val_q;
    imm_d      = imm_q;
    sr2_sel_d  = sr2_sel_q;

    if (capture) begin
      op_valid_d = 1'b1;
      opcode_d   = ir[OPC_HI -: 4];
      dr_d       = ir[DR_HI -: 3];
      sr1_idx_d  = ir_sr1;
      sr2_idx_d  = ir_sr2;
      sr1_val_d  = (wb_en && wb_dr == ir_sr1) ? wb_data : rf_rd1;
      sr2_val_d  = (wb_en && wb_dr == ir_sr2) ? wb_data : rf_rd2;
      imm_d      = sext_imm5(ir[4:0]);
      sr2_sel_d  = ir[IMM_BIT];
    end else if (held) begin
      // Keep the stalled bundle coherent with writebacks landing behind it.
      if (wb_en && wb_dr == sr1_idx_q) sr1_val_d = wb_data;
      if (wb_en && wb_dr == sr2_idx_q) sr2_val_d = wb_data;
    end else if (op_valid_q && op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      opcode_q   <= '0;
      dr_q       <= '0;
      sr1_idx_q  <= '0;
      sr2_idx_q  <= '0;
      sr1_val_q  <= '0;
      sr2_val_q  <= '0;
      imm_q      <= '0;
      sr2_sel_q  <= 1'b0;
    end else begin
      op_valid_q <= op_valid_d;
      opcode_q   <= opcode_d;
      dr_q       <= dr_d;
      sr1_idx_q  <= sr1_idx_d;
      sr2_idx_q  <= sr2_idx_d;
      sr1_val_q  <= sr1_val_d;
      sr2_val_q  <= sr2_val_d;
      imm_q      <= imm_d;
      sr2_sel_q  <= sr2_sel_d;
    end
  end

  assign op_valid  = op_valid_q;
  assign opcode    = opcode_q;
  assign dr        = dr_q;
  assign sr1_val   = sr1_val_q;
  assign sr2_val   = sr2_val_q;
  assign imm5_sext = imm_q;
  assign sr2_sel   = sr2_sel_q;

endmodule

// File: tb/tb_lc3_operand_fetch.sv
// Scoreboard bench for lc3_operand_fetch: a register model predicts each bundle
// at capture time; the held head entry is checked every cycle and popped on accept.
module tb_lc3_operand_fetch;

  typedef struct {
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [15:0] imm;
    logic        sel;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir_valid;
  logic [15:0] ir;
  logic        ir_ready;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  opcode;
  logic [2:0]  dr;
  logic [15:0] sr1_val, sr2_val, imm5_sext;
  logic        sr2_sel;
  logic        wb_en;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;

  bundle_t     sb_q[$];
  logic [15:0] mregs[8];

  always #5 clk = ~clk;

  lc3_operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_valid  (ir_valid),
    .ir        (ir),
    .ir_ready  (ir_ready),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .dr        (dr),
    .sr1_val   (sr1_val),
    .sr2_val   (sr2_val),
    .imm5_sext (imm5_sext),
    .sr2_sel   (sr2_sel),
    .wb_en     (wb_en),
    .wb_dr     (wb_dr),
    .wb_data   (wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, check against the model, advance model, take the edge.
  task automatic cycle(input logic iv, input logic [15:0] iw, input logic ordy,
                       input logic we, input logic [2:0] wd, input logic [15:0] wv);
    bundle_t b;
    logic    exp_valid;
    ir_valid = iv; ir = iw; op_ready = ordy;
    wb_en = we; wb_dr = wd; wb_data = wv;
    #1;
    exp_valid = (sb_q.size() != 0);
    chk("op_valid", {31'b0, op_valid}, {31'b0, exp_valid});
    chk("ir_ready", {31'b0, ir_ready}, {31'b0, !exp_valid || ordy});
    if (exp_valid) begin
      chk("opcode",  {28'b0, opcode},  {28'b0, sb_q[0].opcode});
      chk("dr",      {29'b0, dr},      {29'b0, sb_q[0].dr});
      chk("sr1_val", {16'b0, sr1_val}, {16'b0, sb_q[0].sr1});
      chk("sr2_val", {16'b0, sr2_val}, {16'b0, sb_q[0].sr2});
      chk("imm5",    {16'b0, imm5_sext}, {16'b0, sb_q[0].imm});
      chk("sr2_sel", {31'b0, sr2_sel}, {31'b0, sb_q[0].sel});
    end
    if (exp_valid && ordy) begin
      void'(sb_q.pop_front());
      n_pop++;
    end else if (exp_valid && we) begin
      if (wd == sb_q[0].s1) sb_q[0].sr1 = wv;
      if (wd == sb_q[0].s2) sb_q[0].sr2 = wv;
    end
    if (iv && (!exp_valid || ordy)) begin
      b.opcode = iw[15:12];
      b.dr     = iw[11:9];
      b.s1     = iw[8:6];
      b.s2     = iw[2:0];
      b.sr1    = (we && wd == iw[8:6]) ? wv : mregs[iw[8:6]];
      b.sr2    = (we && wd == iw[2:0]) ? wv : mregs[iw[2:0]];
      b.imm    = iw[4] ? {11'h7FF, iw[4:0]} : {11'h000, iw[4:0]};
      b.sel    = iw[5];
      sb_q.push_back(b);
    end
    if (we) mregs[wd] = wv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pops0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    rst_n = 1'b0; ir_valid = 1'b0; ir = '0; op_ready = 1'b0;
    wb_en = 1'b0; wb_dr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_valid", {31'b0, op_valid}, 32'h0);
    chk("rst_sr1",      {16'b0, sr1_val},  32'h0);
    chk("rst_imm",      {16'b0, imm5_sext}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load R3, then stall a bundle and yank reset while it is held.
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 3'd3, 16'h5555);
    cycle(1'b1, 16'h5EE3, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle(1'b1, 16'h1282, 1'b0, 1'b0, 3'd0, 16'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  {31'b0, op_valid}, 32'h0);
    chk("mid_rst_opcode", {28'b0, opcode},   32'h0);
    chk("mid_rst_dr",     {29'b0, dr},       32'h0);
    chk("mid_rst_sr1",    {16'b0, sr1_val},  32'h0);
    chk("mid_rst_sr2",    {16'b0, sr2_val},  32'h0);
    chk("mid_rst_imm",    {16'b0, imm5_sext}, 32'h0);
    chk("mid_rst_sel",    {31'b0, sr2_sel},  32'h0);
    sb_q.delete();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // R3 must read back as zero after reset.
    cycle(1'b1, 16'h10C3, 1'b1, 1'b0, 3'd0, 16'h0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);

    // Writeback then read: ADD R1,R2,R2.
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 3'd2, 16'h1234);
    cycle(1'b1, 16'h1282, 1'b1, 1'b0, 3'd0, 16'h0);
    chk("t2_sr1", {16'b0, sr1_val}, 32'h1234);
    chk("t2_dr",  {29'b0, dr},      32'h1);
    // Immediate: ADD R0,R1,#-16.
    cycle(1'b1, 16'h1070, 1'b1, 1'b0, 3'd0, 16'h0);
    chk("t3_imm", {16'b0, imm5_sext}, 32'hFFF0);
    chk("t3_sel", {31'b0, sr2_sel},   32'h1);
    // Bypass: ADD R6,R5,R5 captured with R5 writeback on the same edge.
    cycle(1'b1, 16'h1D45, 1'b1, 1'b1, 3'd5, 16'hBEEF);
    chk("t4_sr1", {16'b0, sr1_val}, 32'hBEEF);
    chk("t4_sr2", {16'b0, sr2_val}, 32'hBEEF);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);

    // Backpressure + refresh: ADD R7,R4,R1 held, R4 written while held.
    cycle(1'b1, 16'h1F01, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle(1'b1, 16'h5AA3, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle(1'b1, 16'h5AA3, 1'b0, 1'b1, 3'd4, 16'h0042);
    cycle(1'b1, 16'h5AA3, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("t5_refresh", {16'b0, sr1_val}, 32'h0042);
    chk("t5_stall",   {31'b0, ir_ready}, 32'h0);
    cycle(1'b1, 16'h5AA3, 1'b1, 1'b0, 3'd0, 16'h0);
    chk("t5_next_op", {28'b0, opcode}, 32'h5);

    // Throughput: 8 back-to-back instructions with random writebacks.
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);
    pops0 = n_pop;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 16'($urandom), 1'b1, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 16'($urandom));
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);
    chk("t6_count", 32'(n_pop - pops0), 32'd8);

    // Random mix of backpressure, idle cycles and writebacks.
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
